result_writeback_unit: RTL and testbench

//  Drains the SIZE column results (reduced-PE partial sum + compensation sum) produced by the

---
 rtl/result_writeback_unit.sv | 154 +++++++++++++++
 tb/tb_result_writeback_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_unit.sv
// result_writeback_unit
//   Buffers per-row column-result vectors from the accumulators, then drains
//   them one element per cycle as requantized activations (ReLU, arithmetic
//   right shift, 7-bit saturation) with their activation-memory address.
//
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   frame_start   : pulse, begin draining a SIZE x SIZE frame (accepted in IDLE)
//   quant_shift   : right-shift amount, captured when frame_start is accepted
//   result_in     : SIZE signed columns, column c at [c*RESULT_WIDTH +: RESULT_WIDTH]
//   result_valid  : result_in carries one output-row vector
//   result_ready  : vector buffer has room this cycle
//   act_out       : requantized activation
//   act_addr      : row*SIZE + col
//   act_valid     : act_out / act_addr valid
//   act_ready     : consumer accepts the element this cycle
//   frame_done    : one-cycle pulse after the last element of a frame is accepted
module result_writeback_unit #(
  parameter int SIZE         = 8,
  parameter int RESULT_WIDTH = 22,
  parameter int ADDR_WIDTH   = $clog2(SIZE*SIZE),
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [4:0]                   quant_shift,
  input  logic [SIZE*RESULT_WIDTH-1:0] result_in,
  input  logic                         result_valid,
  output logic                         result_ready,
  output logic [6:0]                   act_out,
  output logic [ADDR_WIDTH-1:0]        act_addr,
  output logic                         act_valid,
  input  logic                         act_ready,
  output logic                         frame_done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [5:0]              SHIFT_LIMIT = 6'(RESULT_WIDTH);
  localparam logic [RESULT_WIDTH-1:0] SAT_MAX     = RESULT_WIDTH'(127);
  localparam logic [CW-1:0]           LAST_IDX    = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [RESULT_WIDTH-1:0] mem [FIFO_DEPTH][SIZE];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [NW-1:0]           count_q;

  logic [CW-1:0] row_q, col_q;
  logic [4:0]    shift_q;

  logic push, pop, hs, col_last, row_last;
  logic [RESULT_WIDTH-1:0] head, shifted;
  logic [6:0]              quant;
  logic [ADDR_WIDTH-1:0]   addr;

  // ---------------- vector FIFO ----------------
  assign result_ready = (count_q < NW'(FIFO_DEPTH));
  assign push         = result_valid && result_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned c = 0; c < SIZE; c++) begin
        mem[wr_ptr][c] <= result_in[c*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- drain control ----------------
  assign act_valid = (state_q == DRAIN) && (count_q != '0);
  assign hs        = act_valid && act_ready;
  assign col_last  = (col_q == LAST_IDX);
  assign row_last  = (row_q == LAST_IDX);
  assign pop       = hs && col_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
    end else if (state_q == IDLE && frame_start) begin
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= quant_shift;
    end else if (hs) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = DRAIN;
      DRAIN:   if (hs && col_last && row_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_done = (state_q == DONE);

  // ---------------- requantization ----------------
  // Element source is FIFO storage, counters and shift_q only, so the
  // outputs hold steady while the consumer stalls.
  assign head = mem[rd_ptr][col_q];

  always_comb begin
    shifted = head >> shift_q;
    quant   = '0;
    if (head[RESULT_WIDTH-1] || ({1'b0, shift_q} >= SHIFT_LIMIT)) quant = '0;
    else if (shifted > SAT_MAX)                                   quant = 7'd127;
    else                                                          quant = shifted[6:0];
  end

  assign addr     = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(SIZE) + ADDR_WIDTH'(col_q);
  assign act_out  = act_valid ? quant : '0;
  assign act_addr = act_valid ? addr  : '0;

endmodule

// File: tb/tb_result_writeback_unit.sv
module tb_result_writeback_unit;
  localparam int SIZE = 8;
  localparam int RW   = 22;
  localparam int AW   = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic [4:0]       quant_shift;
  logic [SIZE*RW-1:0] result_in;
  logic             result_valid;
  logic             result_ready;
  logic [6:0]       act_out;
  logic [AW-1:0]    act_addr;
  logic             act_valid;
  logic             act_ready;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_writeback_unit #(
    .SIZE(SIZE),
    .RESULT_WIDTH(RW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .quant_shift(quant_shift),
    .result_in(result_in),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .act_out(act_out),
    .act_addr(act_addr),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Edge-case column values; all rows of a kind-1 frame use this vector.
  function automatic logic [RW-1:0] special_val(input int c);
    case (c)
      0:       return RW'(-5);
      1:       return RW'(0);
      2:       return RW'(2047);
      3:       return RW'(2097151);
      4:       return RW'(100);
      5:       return RW'(-2097152);
      6:       return RW'(16);
      default: return RW'(2048);
    endcase
  endfunction

  // kind 0: (r*8+c)*16; kind 1: special values; kind 2: marker 99*16
  function automatic logic [SIZE*RW-1:0] make_vec(input int kind, input int r);
    logic [SIZE*RW-1:0] v;
    v = '0;
    for (int c = 0; c < SIZE; c++) begin
      if (kind == 0)      v[c*RW +: RW] = RW'((r*8 + c) * 16);
      else if (kind == 1) v[c*RW +: RW] = special_val(c);
      else                v[c*RW +: RW] = RW'(99 * 16);
    end
    return v;
  endfunction

  function automatic int expect_out(input int kind, input int shift, input int idx);
    int v;
    if (kind == 0) begin
      v = (idx * 16) >> shift;
      return (v > 127) ? 127 : v;
    end
    if (shift >= 22) return 0;
    // shift 4: -5,0,2047,2097151,100,-2097152,16,2048
    case (idx % 8)
      0: return 0;
      1: return 0;
      2: return 127;
      3: return 127;
      4: return 6;
      5: return 0;
      6: return 1;
      default: return 127;
    endcase
  endfunction

  // rmode 0: act_ready=1; rmode 1: act_ready pattern 1,0,0,1
  // pmode 0: push whenever possible; pmode 1: push next row on the col-7 pop
  task automatic run_frame(input int kind, input int shift, input int rmode,
                           input int pmode, input int start_pushed, input int abort_at);
    int pushed = start_pushed;
    int idx = 0;
    int n = 0;
    logic hs, acc, held;
    logic [6:0] h_out;
    logic [AW-1:0] h_addr;
    quant_shift = 5'(shift);
    frame_start = 1'b1;
    while (idx < 64 && idx != abort_at && n < 2000) begin
      act_ready = (rmode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      hs = act_valid && act_ready;
      if (pmode == 0) result_valid = (pushed < 8);
      else result_valid = (pushed < 8) && (pushed == 0 || (hs && act_addr[2:0] == 3'd7));
      result_in = make_vec(kind, pushed);
      acc = result_valid && result_ready;
      held = act_valid && !act_ready;
      h_out = act_out;
      h_addr = act_addr;
      cyc();
      frame_start = 1'b0;
      n++;
      if (acc) pushed++;
      if (hs) idx++;
      if (act_valid) begin
        if (held) begin
          chk("hold_out", act_out, h_out);
          chk("hold_addr", act_addr, h_addr);
        end
        chk("addr", act_addr, idx);
        chk("out", act_out, expect_out(kind, shift, idx));
      end
      chk("frame_done", frame_done, idx == 64);
      if (pmode == 1 && idx < 64) begin
        chk("no_gap_valid", act_valid, 1);
        chk("no_gap_ready", result_ready, 1);
      end
    end
    result_valid = 1'b0;
    chk("progress", idx, (abort_at < 64) ? abort_at : 64);
    if (idx == 64) begin
      cyc();
      chk("done_clear", frame_done, 0);
      chk("idle_valid", act_valid, 0);
      chk("idle_addr", act_addr, 0);
      chk("idle_ready", result_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    quant_shift = '0;
    result_in = '0;
    result_valid = 1'b0;
    act_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", result_ready, 1);
    chk("rst_valid", act_valid, 0);
    chk("rst_out", act_out, 0);
    chk("rst_addr", act_addr, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    cyc();

    // main streaming frame, then a saturating shift
    run_frame(0, 4, 0, 0, 0, 64);
    run_frame(0, 2, 0, 0, 0, 64);

    // negative / large values and shift >= width
    run_frame(1, 4, 0, 0, 0, 64);
    run_frame(1, 22, 0, 0, 0, 64);

    // consumer stalls
    run_frame(0, 4, 1, 0, 0, 64);

    // push coincides with col-7 pop at count 1
    run_frame(0, 4, 0, 1, 0, 64);

    // reset mid-frame at row 3
    run_frame(0, 4, 0, 0, 0, 24);
    rst = 1'b1;
    result_valid = 1'b0;
    cyc();
    chk("midrst_valid", act_valid, 0);
    chk("midrst_ready", result_ready, 1);
    chk("midrst_done", frame_done, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("midrst_nodone", frame_done, 0);
      chk("midrst_novalid", act_valid, 0);
    end
    run_frame(0, 4, 0, 0, 0, 64);

    // three pushes with no frame: third must be refused
    result_valid = 1'b1;
    result_in = make_vec(0, 0);
    cyc();
    chk("fill1_ready", result_ready, 1);
    result_in = make_vec(0, 1);
    cyc();
    chk("fill2_ready", result_ready, 0);
    chk("fill2_valid", act_valid, 0);
    result_in = make_vec(2, 0);
    cyc();
    chk("fill3_ready", result_ready, 0);
    chk("fill3_valid", act_valid, 0);
    result_valid = 1'b0;
    run_frame(0, 4, 0, 0, 2, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
